conv_framer: RTL and testbench

CONV_FRAMER -- requirements
Module: conv_framer

---
 rtl/conv_framer.sv | 172 +++++++++++++++++
 tb/tb_conv_framer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_framer.sv
// Raw pixel stream to AXI4-Stream video framer (tuser = start of frame, tlast = end of line).
// Define CONV_FRAMER_FRAME_CNT_EN to build the completed-frame counter behind frame_cnt_o.
module conv_framer #(
    parameter int PIXEL_W = 8,
    parameter int COL_W   = 12,
    parameter int ROW_W   = 12
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [COL_W-1:0]   cfg_width_i,
    input  logic [ROW_W-1:0]   cfg_height_i,
    input  logic               px_valid_i,
    input  logic [PIXEL_W-1:0] px_data_i,
    output logic               px_ready_o,
    output logic               m_tvalid_o,
    output logic [PIXEL_W-1:0] m_tdata_o,
    output logic               m_tuser_o,
    output logic               m_tlast_o,
    input  logic               m_tready_i,
    output logic               busy_o,
    output logic [15:0]        frame_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_latch;
    logic [COL_W-1:0]   r_width;
    logic [ROW_W-1:0]   r_height;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_tvalid;
    logic [PIXEL_W-1:0] r_tdata;
    logic               r_tuser;
    logic               r_tlast;
    logic               r_busy;

    logic w_cfg_ok;
    logic w_ready;
    logic w_accept;
    logic w_last_col;
    logic w_last_row;
    logic w_first_px;
    logic w_frame_done;

    assign w_cfg_ok     = en_i && (cfg_width_i != {COL_W{1'b0}}) && (cfg_height_i != {ROW_W{1'b0}});
    assign w_ready      = (r_state == ST_ACTIVE) && (!r_tvalid || m_tready_i);
    assign w_accept     = px_valid_i && w_ready;
    assign w_last_col   = (r_col == (r_width - COL_W'(1)));
    assign w_last_row   = (r_row == (r_height - ROW_W'(1)));
    assign w_first_px   = (r_col == {COL_W{1'b0}}) && (r_row == {ROW_W{1'b0}});
    assign w_frame_done = w_accept && w_last_col && w_last_row;

    // Next-state logic; a frame only ends on its final accepted pixel, so en_i never truncates one.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_ok) begin
                    w_state_nxt = ST_ACTIVE;
                    w_latch     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_frame_done) begin
                    if (w_cfg_ok) begin
                        w_state_nxt = ST_ACTIVE;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_ACTIVE);
        end
    end

    // Geometry latch and column/row position within the frame.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_width  <= {COL_W{1'b0}};
            r_height <= {ROW_W{1'b0}};
            r_col    <= {COL_W{1'b0}};
            r_row    <= {ROW_W{1'b0}};
        end else begin
            if (w_latch) begin
                r_width  <= cfg_width_i;
                r_height <= cfg_height_i;
            end
            if (w_accept) begin
                if (w_last_col) begin
                    r_col <= {COL_W{1'b0}};
                    if (w_last_row) begin
                        r_row <= {ROW_W{1'b0}};
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end else if (r_state == ST_IDLE) begin
                r_col <= {COL_W{1'b0}};
                r_row <= {ROW_W{1'b0}};
            end
        end
    end

    // Output skid register: loads on acceptance, holds while stalled, drains on ready.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_tvalid <= 1'b0;
            r_tdata  <= {PIXEL_W{1'b0}};
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_accept) begin
            r_tvalid <= 1'b1;
            r_tdata  <= px_data_i;
            r_tuser  <= w_first_px;
            r_tlast  <= w_last_col;
        end else if (m_tready_i) begin
            r_tvalid <= 1'b0;
        end
    end

`ifdef CONV_FRAMER_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Completed-frame counter, wraps modulo 2^16.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt_o = r_frame_cnt;
`else
    assign frame_cnt_o = 16'd0;
`endif

    assign px_ready_o = w_ready;
    assign m_tvalid_o = r_tvalid;
    assign m_tdata_o  = r_tdata;
    assign m_tuser_o  = r_tuser;
    assign m_tlast_o  = r_tlast;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_conv_framer.sv
// Directed self-checking bench for conv_framer (default parameters).
module tb_conv_framer;

    logic        clk_i;
    logic        rst_n;
    logic        en_i;
    logic [11:0] cfg_width_i;
    logic [11:0] cfg_height_i;
    logic        px_valid_i;
    logic [7:0]  px_data_i;
    logic        px_ready_o;
    logic        m_tvalid_o;
    logic [7:0]  m_tdata_o;
    logic        m_tuser_o;
    logic        m_tlast_o;
    logic        m_tready_i;
    logic        busy_o;
    logic [15:0] frame_cnt_o;

    int checks = 0;
    int errors = 0;

    int n_acc  = 0;
    int n_beat = 0;
    int beat_base;
    int acc_base;
    logic [7:0] bt_data [0:255];
    logic       bt_user [0:255];
    logic       bt_last [0:255];

    conv_framer dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .px_valid_i   (px_valid_i),
        .px_data_i    (px_data_i),
        .px_ready_o   (px_ready_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tdata_o    (m_tdata_o),
        .m_tuser_o    (m_tuser_o),
        .m_tlast_o    (m_tlast_o),
        .m_tready_i   (m_tready_i),
        .busy_o       (busy_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] pix(input int k);
        pix = 8'((k * 37 + 5) & 255);
    endfunction

    // Record handshakes on the falling edge; they complete on the following rising edge.
    always @(negedge clk_i) begin
        if (rst_n && m_tvalid_o && m_tready_i && n_beat < 256) begin
            bt_data[n_beat] <= m_tdata_o;
            bt_user[n_beat] <= m_tuser_o;
            bt_last[n_beat] <= m_tlast_o;
            n_beat          <= n_beat + 1;
        end
        if (rst_n && px_valid_i && px_ready_o) begin
            n_acc <= n_acc + 1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        px_data_i = pix(n_acc);
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (n_beat - beat_base >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (n_beat - beat_base >= target) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_i = 1'b0; px_valid_i = 1'b1; m_tready_i = 1'b1;
        cfg_width_i = 12'd0; cfg_height_i = 12'd0; px_data_i = 8'd0;
        tick(); tick();
        checks++; if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid_o); end
        checks++; if (m_tdata_o !== 8'd0) begin errors++; $display("FAIL reset_tdata got %h exp 00", m_tdata_o); end
        checks++; if ({m_tuser_o, m_tlast_o} !== 2'b00) begin errors++; $display("FAIL reset_user_last got %b exp 00", {m_tuser_o, m_tlast_o}); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt_o); end
        checks++; if (px_ready_o !== 1'b0) begin errors++; $display("FAIL reset_px_ready got %b exp 0", px_ready_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_cfg();
        en_i = 1'b1; cfg_width_i = 12'd0; cfg_height_i = 12'd2;
        tick(); tick(); tick();
        checks++; if ({busy_o, px_ready_o} !== 2'b00) begin errors++; $display("FAIL zero_width busy/ready got %b exp 00", {busy_o, px_ready_o}); end
        cfg_width_i = 12'd3; cfg_height_i = 12'd0;
        tick(); tick(); tick();
        checks++; if ({busy_o, px_ready_o} !== 2'b00) begin errors++; $display("FAIL zero_height busy/ready got %b exp 00", {busy_o, px_ready_o}); end
        en_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        beat_base = n_beat; acc_base = n_acc;
        cfg_width_i = 12'd4; cfg_height_i = 12'd2; en_i = 1'b1;
        wait_beats(8, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout8 got %0d beats exp 8", n_beat - beat_base); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy_o); end
        wait_beats(9, 10, ok);
        en_i = 1'b0;
        wait_beats(16, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout16 got %0d beats exp 16", n_beat - beat_base); end
        tick(); tick(); tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bt_data[beat_base+i] !== pix(acc_base + i) || bt_user[beat_base+i] !== ((i % 8) == 0)
                || bt_last[beat_base+i] !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL b2b_beat%0d got d=%h u=%b l=%b exp d=%h u=%b l=%b", i, bt_data[beat_base+i],
                         bt_user[beat_base+i], bt_last[beat_base+i], pix(acc_base + i), (i % 8) == 0, (i % 4) == 3);
            end
        end
        checks++; if (n_beat - beat_base !== 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", n_beat - beat_base); end
        checks++; if ({busy_o, px_ready_o} !== 2'b00) begin errors++; $display("FAIL b2b_idle busy/ready got %b exp 00", {busy_o, px_ready_o}); end
    endtask

    task automatic test_one_by_one();
        bit ok;
        beat_base = n_beat; acc_base = n_acc;
        cfg_width_i = 12'd1; cfg_height_i = 12'd1; en_i = 1'b1;
        tick();
        en_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL 1x1_busy got %b exp 1", busy_o); end
        wait_beats(1, 10, ok);
        tick(); tick(); tick();
        checks++; if (n_beat - beat_base !== 1) begin errors++; $display("FAIL 1x1_count got %0d exp 1", n_beat - beat_base); end
        checks++;
        if (bt_data[beat_base] !== pix(acc_base) || bt_user[beat_base] !== 1'b1 || bt_last[beat_base] !== 1'b1) begin
            errors++;
            $display("FAIL 1x1_beat got d=%h u=%b l=%b exp d=%h u=1 l=1", bt_data[beat_base], bt_user[beat_base],
                     bt_last[beat_base], pix(acc_base));
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL 1x1_idle got %b exp 0", busy_o); end
    endtask

    task automatic test_stall();
        bit ok;
        beat_base = n_beat; acc_base = n_acc;
        cfg_width_i = 12'd3; cfg_height_i = 12'd3; en_i = 1'b1;
        tick();
        en_i = 1'b0;
        wait_beats(4, 20, ok);
        m_tready_i = 1'b0;
        #1;
        checks++; if (px_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", px_ready_o); end
        for (int c = 0; c < 5; c++) begin
            tick();
            px_data_i = 8'hEE;
            checks++;
            if (m_tvalid_o !== 1'b1 || m_tdata_o !== pix(acc_base + 4) || m_tuser_o !== 1'b0
                || m_tlast_o !== 1'b0 || px_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b d=%h u=%b l=%b r=%b exp v=1 d=%h u=0 l=0 r=0", c, m_tvalid_o,
                         m_tdata_o, m_tuser_o, m_tlast_o, px_ready_o, pix(acc_base + 4));
            end
        end
        m_tready_i = 1'b1;
        px_data_i = pix(n_acc);
        wait_beats(9, 40, ok);
        tick(); tick(); tick();
        checks++; if (n_beat - beat_base !== 9) begin errors++; $display("FAIL stall_count got %0d exp 9", n_beat - beat_base); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bt_data[beat_base+i] !== pix(acc_base + i) || bt_user[beat_base+i] !== (i == 0)
                || bt_last[beat_base+i] !== ((i % 3) == 2)) begin
                errors++;
                $display("FAIL stall_beat%0d got d=%h u=%b l=%b exp d=%h", i, bt_data[beat_base+i],
                         bt_user[beat_base+i], bt_last[beat_base+i], pix(acc_base + i));
            end
        end
    endtask

    task automatic test_en_drop();
        bit ok;
        beat_base = n_beat; acc_base = n_acc;
        cfg_width_i = 12'd4; cfg_height_i = 12'd2; en_i = 1'b1;
        wait_beats(2, 20, ok);
        en_i = 1'b0; cfg_width_i = 12'd2; cfg_height_i = 12'd1;
        wait_beats(8, 40, ok);
        tick(); tick(); tick();
        checks++; if (n_beat - beat_base !== 8) begin errors++; $display("FAIL endrop_count got %0d exp 8", n_beat - beat_base); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bt_data[beat_base+i] !== pix(acc_base + i) || bt_user[beat_base+i] !== (i == 0)
                || bt_last[beat_base+i] !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL endrop_beat%0d got d=%h u=%b l=%b exp d=%h", i, bt_data[beat_base+i],
                         bt_user[beat_base+i], bt_last[beat_base+i], pix(acc_base + i));
            end
        end
        checks++; if ({busy_o, px_ready_o} !== 2'b00) begin errors++; $display("FAIL endrop_idle busy/ready got %b exp 00", {busy_o, px_ready_o}); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        beat_base = n_beat;
        cfg_width_i = 12'd4; cfg_height_i = 12'd4; en_i = 1'b1;
        wait_beats(5, 30, ok);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_tvalid_o, m_tuser_o, m_tlast_o, busy_o} !== 4'b0000 || m_tdata_o !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got v=%b u=%b l=%b b=%b d=%h exp all 0", m_tvalid_o, m_tuser_o,
                     m_tlast_o, busy_o, m_tdata_o);
        end
        tick();
        rst_n = 1'b1;
        beat_base = n_beat; acc_base = n_acc;
        wait_beats(4, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got %0d beats exp 4", n_beat - beat_base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bt_data[beat_base+i] !== pix(acc_base + i) || bt_user[beat_base+i] !== (i == 0)
                || bt_last[beat_base+i] !== (i == 3)) begin
                errors++;
                $display("FAIL rstmid_beat%0d got d=%h u=%b l=%b exp d=%h", i, bt_data[beat_base+i],
                         bt_user[beat_base+i], bt_last[beat_base+i], pix(acc_base + i));
            end
        end
        en_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_frame_cnt();
        bit ok;
        logic [15:0] exp_cnt;
`ifdef CONV_FRAMER_FRAME_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        beat_base = n_beat; acc_base = n_acc;
        cfg_width_i = 12'd2; cfg_height_i = 12'd2; en_i = 1'b1;
        wait_beats(9, 40, ok);
        en_i = 1'b0;
        wait_beats(12, 40, ok);
        tick(); tick(); tick();
        checks++; if (n_beat - beat_base !== 12) begin errors++; $display("FAIL fcnt_count got %0d exp 12", n_beat - beat_base); end
        checks++; if (bt_user[beat_base+8] !== 1'b1 || bt_last[beat_base+11] !== 1'b1) begin errors++; $display("FAIL fcnt_markers got u=%b l=%b exp 1 1", bt_user[beat_base+8], bt_last[beat_base+11]); end
        checks++; if (frame_cnt_o !== exp_cnt) begin errors++; $display("FAIL fcnt_value got %0d exp %0d", frame_cnt_o, exp_cnt); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fcnt_idle got %b exp 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_zero_cfg();
        test_back_to_back();
        test_one_by_one();
        test_stall();
        test_en_drop();
        test_reset_mid_frame();
        test_frame_cnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
